// File: rtl/display_pkg.sv
// Shared constants for the 7-segment display path: active-low glyphs,
// digit slot indices and the settle FSM state type.
package display_pkg;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] DIG_UNITS     = 2'd0;
  localparam logic [1:0] DIG_TENS      = 2'd1;
  localparam logic [1:0] DIG_HUNDREDS  = 2'd2;
  localparam logic [1:0] DIG_THOUSANDS = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLING = 2'd1,
    SAMPLED  = 2'd2
  } settle_state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of an active-low 7-segment pattern back to BCD.
// The all-off pattern is reported separately so the caller decides its meaning.
module seg7_to_bcd
  import display_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       is_blank_o,
  output logic       is_valid_o
);

  always_comb begin
    bcd_o      = 4'd0;
    is_blank_o = 1'b0;
    is_valid_o = 1'b1;
    case (seg_i)
      SEG_0:     bcd_o = 4'd0;
      SEG_1:     bcd_o = 4'd1;
      SEG_2:     bcd_o = 4'd2;
      SEG_3:     bcd_o = 4'd3;
      SEG_4:     bcd_o = 4'd4;
      SEG_5:     bcd_o = 4'd5;
      SEG_6:     bcd_o = 4'd6;
      SEG_7:     bcd_o = 4'd7;
      SEG_8:     bcd_o = 4'd8;
      SEG_9:     bcd_o = 4'd9;
      SEG_BLANK: begin
        is_blank_o = 1'b1;
        is_valid_o = 1'b0;
      end
      default:   is_valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/display_capture.sv
// Decodes the multiplexed 7-segment bus back into confirmed 16-bit BCD frames.
// Define DISPLAY_CAPTURE_BLANK_EN to accept all-off digits as blank zeros.
module display_capture
  import display_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int CONFIRM_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  segments,
  input  logic [3:0]  display_select,
  output logic [15:0] bcd_value,
  output logic        value_valid,
  output logic [3:0]  blank_mask,
  output logic        frame_error,
  output logic [1:0]  dbg_state
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = $clog2(CONFIRM_FRAMES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CONF_MAX    = CW'(CONFIRM_FRAMES);
`ifdef DISPLAY_CAPTURE_BLANK_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif

  settle_state_e   state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [3:0]      prev_sel_q;
  logic [6:0]      prev_seg_q;
  logic [3:0]      mask_q, mask_d;
  logic [3:0][3:0] slots_q, slots_d;
  logic [3:0]      sblank_q, sblank_d;
  logic [19:0]     prev_frame_q, prev_frame_d;
  logic            prev_fv_q, prev_fv_d;
  logic [CW-1:0]   stable_q, stable_d;
  logic [15:0]     bcd_q, bcd_d;
  logic [3:0]      blank_out_q, blank_out_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic        sel_legal, sel_gap, sel_illegal, inputs_changed, take_sample;
  logic [1:0]  sel_idx;
  logic [3:0]  dec_bcd;
  logic        dec_blank, dec_valid, digit_ok, digit_blank, record, bad_glyph;
  logic [19:0] frame_cur;
  logic        same_frame;

  always_comb begin
    sel_legal = 1'b1;
    sel_idx   = DIG_UNITS;
    case (display_select)
      4'b1110: sel_idx = DIG_UNITS;
      4'b1101: sel_idx = DIG_TENS;
      4'b1011: sel_idx = DIG_HUNDREDS;
      4'b0111: sel_idx = DIG_THOUSANDS;
      default: sel_legal = 1'b0;
    endcase
  end

  assign sel_gap        = (display_select == 4'b1111);
  assign sel_illegal    = !sel_legal && !sel_gap;
  assign inputs_changed = (display_select != prev_sel_q) || (segments != prev_seg_q);

  // Settle FSM: one sample per dwell, on the SETTLE_CYCLES-th stable cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    take_sample = 1'b0;
    if (!sel_legal) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE || inputs_changed) begin
      cnt_d = SW'(1);
      if (SETTLE_CYCLES == 1) begin
        state_d     = SAMPLED;
        take_sample = 1'b1;
      end else begin
        state_d = SETTLING;
      end
    end else if (state_q == SETTLING) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == SETTLE_LAST) begin
        state_d     = SAMPLED;
        take_sample = 1'b1;
      end
    end
  end

  seg7_to_bcd u_dec (
    .seg_i      (segments),
    .bcd_o      (dec_bcd),
    .is_blank_o (dec_blank),
    .is_valid_o (dec_valid)
  );

  assign digit_ok    = dec_valid || (dec_blank && BLANK_EN);
  assign digit_blank = dec_blank && BLANK_EN;
  assign record      = take_sample && digit_ok;
  assign bad_glyph   = take_sample && !digit_ok;

  // Frame assembly, confirmation and publish.
  always_comb begin
    mask_d       = mask_q;
    slots_d      = slots_q;
    sblank_d     = sblank_q;
    prev_frame_d = prev_frame_q;
    prev_fv_d    = prev_fv_q;
    stable_d     = stable_q;
    bcd_d        = bcd_q;
    blank_out_d  = blank_out_q;
    valid_d      = 1'b0;
    err_d        = err_q;
    frame_cur    = '0;
    same_frame   = 1'b0;
    if (record) begin
      if (mask_q == 4'b0000) err_d = 1'b0;
      slots_d[sel_idx]  = dec_bcd;
      sblank_d[sel_idx] = digit_blank;
      mask_d            = mask_q | ~display_select;
      if (mask_d == 4'b1111) begin
        mask_d     = 4'b0000;
        frame_cur  = {sblank_d, slots_d};
        same_frame = prev_fv_q && (frame_cur == prev_frame_q);
        if (!same_frame) stable_d = CW'(1);
        else if (stable_q != CONF_MAX) stable_d = stable_q + 1'b1;
        prev_frame_d = frame_cur;
        prev_fv_d    = 1'b1;
        // A run that was already confirmed is not re-published.
        if (stable_d == CONF_MAX && !(same_frame && stable_q == CONF_MAX)) begin
          valid_d     = 1'b1;
          bcd_d       = slots_d;
          blank_out_d = sblank_d;
        end
      end
    end
    if (sel_illegal || bad_glyph) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      prev_sel_q   <= 4'b1111;
      prev_seg_q   <= SEG_BLANK;
      mask_q       <= '0;
      slots_q      <= '0;
      sblank_q     <= '0;
      prev_frame_q <= '0;
      prev_fv_q    <= 1'b0;
      stable_q     <= '0;
      bcd_q        <= '0;
      blank_out_q  <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_sel_q   <= display_select;
      prev_seg_q   <= segments;
      mask_q       <= mask_d;
      slots_q      <= slots_d;
      sblank_q     <= sblank_d;
      prev_frame_q <= prev_frame_d;
      prev_fv_q    <= prev_fv_d;
      stable_q     <= stable_d;
      bcd_q        <= bcd_d;
      blank_out_q  <= blank_out_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign bcd_value   = bcd_q;
  assign value_valid = valid_q;
  assign blank_mask  = blank_out_q;
  assign frame_error = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_display_capture.sv
// Randomized bench for display_capture against a dwell/frame-level reference model.
// Builds with or without DISPLAY_CAPTURE_BLANK_EN.
module tb_display_capture;

  localparam int SETTLE  = 4;
  localparam int CONFIRM = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  segments = 7'h7F;
  logic [3:0]  display_select = 4'hF;
  logic [15:0] bcd_value;
  logic        value_valid;
  logic [3:0]  blank_mask;
  logic        frame_error;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int dut_pulses = 0;

  logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  display_capture #(.SETTLE_CYCLES(SETTLE), .CONFIRM_FRAMES(CONFIRM)) dut (
    .clk            (clk),
    .reset          (reset),
    .segments       (segments),
    .display_select (display_select),
    .bcd_value      (bcd_value),
    .value_valid    (value_valid),
    .blank_mask     (blank_mask),
    .frame_error    (frame_error),
    .dbg_state      (dbg_state)
  );

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] exp_bcd = '0;
  logic        exp_valid = 1'b0;
  logic [3:0]  exp_blank = '0;
  logic        exp_err = 1'b0;
  logic [15:0] exp_q [$];

  int          run_len = 0;
  logic [3:0]  last_sel = 4'hF;
  logic [6:0]  last_seg = 7'h7F;
  logic [3:0]  m_digit [4];
  bit          m_blank [4];
  bit          m_got [4];
  logic [19:0] last_frame = '0;
  bit          have_last = 1'b0;
  int          same_run = 0;

  task automatic model_sample(input int idx, input logic [6:0] g);
    int d;
    bit blank;
    logic [19:0] frame;
    d = -1;
    blank = 1'b0;
    for (int k = 0; k < 10; k++) if (glyph[k] == g) d = k;
`ifdef DISPLAY_CAPTURE_BLANK_EN
    if (g == 7'h7F) begin d = 0; blank = 1'b1; end
`endif
    if (d < 0) begin
      exp_err = 1'b1;
      return;
    end
    if (!m_got[0] && !m_got[1] && !m_got[2] && !m_got[3]) exp_err = 1'b0;
    m_digit[idx] = d[3:0];
    m_blank[idx] = blank;
    m_got[idx]   = 1'b1;
    if (m_got[0] && m_got[1] && m_got[2] && m_got[3]) begin
      frame = {m_blank[3], m_blank[2], m_blank[1], m_blank[0],
               m_digit[3], m_digit[2], m_digit[1], m_digit[0]};
      for (int k = 0; k < 4; k++) m_got[k] = 1'b0;
      if (have_last && frame == last_frame) same_run++;
      else same_run = 1;
      have_last  = 1'b1;
      last_frame = frame;
      if (same_run == CONFIRM) begin
        exp_valid = 1'b1;
        exp_bcd   = frame[15:0];
        exp_blank = frame[19:16];
        exp_q.push_back(frame[15:0]);
      end
    end
  endtask

  always @(posedge clk) begin
    int idx;
    exp_valid = 1'b0;
    if (reset) begin
      exp_bcd = '0; exp_blank = '0; exp_err = 1'b0;
      run_len = 0; have_last = 1'b0; same_run = 0; last_frame = '0;
      for (int k = 0; k < 4; k++) begin m_got[k] = 1'b0; m_digit[k] = '0; m_blank[k] = 1'b0; end
    end else begin
      idx = -1;
      for (int k = 0; k < 4; k++) if (display_select == ~(4'b0001 << k)) idx = k;
      if (display_select == 4'hF) run_len = 0;
      else if (idx < 0) begin
        run_len = 0;
        exp_err = 1'b1;
      end else begin
        if (run_len > 0 && display_select == last_sel && segments == last_seg) run_len++;
        else run_len = 1;
        if (run_len == SETTLE) model_sample(idx, segments);
      end
    end
    last_sel = display_select;
    last_seg = segments;
  end

  // ---------------- scoreboard / per-cycle compare ----------------
  always @(negedge clk) begin
    check("bcd_value", {4'h0, bcd_value}, {4'h0, exp_bcd});
    check("value_valid", {19'h0, value_valid}, {19'h0, exp_valid});
    check("blank_mask", {16'h0, blank_mask}, {16'h0, exp_blank});
    check("frame_error", {19'h0, frame_error}, {19'h0, exp_err});
    if (value_valid) begin
      dut_pulses++;
      if (exp_q.size() == 0) check("unexpected_publish", {4'h0, bcd_value}, 20'hFFFFF);
      else check("published_value", {4'h0, bcd_value}, {4'h0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic dwell(input logic [3:0] sel, input logic [6:0] seg, input int n);
    display_select = sel;
    segments       = seg;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dwell(4'hF, 7'h7F, 2);
    reset = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] v, input logic [3:0] blanks, input int len, input bit glitch);
    logic [3:0] s;
    logic [3:0] d;
    for (int i = 0; i < 4; i++) begin
      s = 4'b0001 << i;
      s = ~s;
      d = v[i*4 +: 4];
      if (glitch) dwell(s, glyph[(d + 5) % 10], 3);
      dwell(s, blanks[i] ? 7'h7F : glyph[d], len);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    int reps;
    logic [15:0] v;
    logic [3:0]  bl;
    logic [3:0]  s;

    do_reset();
    check("reset_bcd", {4'h0, bcd_value}, 20'h0);
    check("reset_valid", {19'h0, value_valid}, 20'h0);
    check("reset_blank", {16'h0, blank_mask}, 20'h0);
    check("reset_err", {19'h0, frame_error}, 20'h0);
    check("reset_state", {18'h0, dbg_state}, 20'h0);

    // 1234 twice: one publish
    p0 = dut_pulses;
    send_frame(16'h1234, 4'b0000, 8, 1'b0);
    check("no_publish_first_frame", dut_pulses - p0, 20'd0);
    send_frame(16'h1234, 4'b0000, 8, 1'b0);
    check("pulses_1234", dut_pulses - p0, 20'd1);
    check("value_1234", {4'h0, bcd_value}, 20'h01234);
    check("err_1234", {19'h0, frame_error}, 20'h0);

    // 0786 with blank thousands
    p0 = dut_pulses;
    send_frame(16'h0786, 4'b1000, 8, 1'b0);
    send_frame(16'h0786, 4'b1000, 8, 1'b0);
`ifdef DISPLAY_CAPTURE_BLANK_EN
    check("pulses_0786", dut_pulses - p0, 20'd1);
    check("value_0786", {4'h0, bcd_value}, 20'h00786);
    check("blank_0786", {16'h0, blank_mask}, 20'h8);
`else
    check("pulses_0786", dut_pulses - p0, 20'd0);
    check("err_0786", {19'h0, frame_error}, 20'h1);
    check("value_kept", {4'h0, bcd_value}, 20'h01234);
`endif

    // glitch dwells shorter than the settle time
    do_reset();
    p0 = dut_pulses;
    send_frame(16'h1234, 4'b0000, 8, 1'b1);
    send_frame(16'h1234, 4'b0000, 8, 1'b1);
    check("pulses_glitch", dut_pulses - p0, 20'd1);
    check("value_glitch", {4'h0, bcd_value}, 20'h01234);

    // illegal select then recovery on the next recorded digit
    do_reset();
    dwell(4'b1100, glyph[0], 1);
    check("err_illegal_sel", {19'h0, frame_error}, 20'h1);
    dwell(4'b1100, glyph[0], 5);
    dwell(4'b1110, glyph[4], 3);
    check("err_before_record", {19'h0, frame_error}, 20'h1);
    dwell(4'b1110, glyph[4], 5);
    check("err_cleared", {19'h0, frame_error}, 20'h0);

    // stable run publishes once; a one-frame change then re-confirm
    do_reset();
    p0 = dut_pulses;
    repeat (5) send_frame(16'h1234, 4'b0000, 8, 1'b0);
    check("pulses_stable5", dut_pulses - p0, 20'd1);
    send_frame(16'h1235, 4'b0000, 8, 1'b0);
    send_frame(16'h1234, 4'b0000, 8, 1'b0);
    send_frame(16'h1234, 4'b0000, 8, 1'b0);
    check("pulses_rerun", dut_pulses - p0, 20'd2);
    check("value_rerun", {4'h0, bcd_value}, 20'h01234);

    // reset mid-frame
    dwell(4'b1110, glyph[9], 8);
    dwell(4'b1101, glyph[9], 8);
    do_reset();
    check("midreset_bcd", {4'h0, bcd_value}, 20'h0);
    check("midreset_err", {19'h0, frame_error}, 20'h0);
    p0 = dut_pulses;
    send_frame(16'h5678, 4'b0000, 8, 1'b0);
    send_frame(16'h5678, 4'b0000, 8, 1'b0);
    check("pulses_after_reset", dut_pulses - p0, 20'd1);
    check("value_after_reset", {4'h0, bcd_value}, 20'h05678);

    // randomized frames with glitches, gaps, illegal selects and resets
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 4; k++) v[k*4 +: 4] = 4'($urandom_range(0, 9));
      bl   = ($urandom_range(0, 4) == 0) ? 4'b1000 : 4'b0000;
      reps = $urandom_range(1, 3);
      for (int r = 0; r < reps; r++) begin
        for (int k = 0; k < 4; k++) begin
          if ($urandom_range(0, 4) == 0)
            dwell(4'($urandom), 7'($urandom), $urandom_range(1, 3));
          if ($urandom_range(0, 3) == 0) dwell(4'hF, 7'h7F, $urandom_range(1, 2));
          s = 4'b0001 << k;
          s = ~s;
          dwell(s, bl[k] ? 7'h7F : glyph[v[k*4 +: 4]], $urandom_range(3, 10));
        end
      end
      if ($urandom_range(0, 19) == 0) do_reset();
    end
    dwell(4'hF, 7'h7F, 4);

    check("all_publishes_seen", exp_q.size(), 20'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_capture.md
# display_capture

Receive-side counterpart of the display multiplexer. Monitors the multiplexed 7-segment bus (`segments`, `display_select`) and decodes each settled digit back to BCD. It assembles the four digits into a frame and publishes a confirmed 16-bit BCD value with a one-cycle valid pulse. It sits beside the display path for on-chip self-check and loopback verification of the multiplier result display.

## Interface
Parameters:
- `SETTLE_CYCLES`, 4: consecutive cycles with `display_select` and `segments` both unchanged before a digit is sampled (≥1).
- `CONFIRM_FRAMES`, 2: consecutive identical complete frames required before publishing (≥1).

Ports (one clock; reset is synchronous and active-high):
- `clk`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high.
- `segments`, input, 7: active-low pattern, bit order {g,f,e,d,c,b,a}.
- `display_select`, input, 4: active-low one-hot digit enable. Bit0 = units, bit1 = tens, bit2 = hundreds, bit3 = thousands.
- `bcd_value`, output, 16: published value {thousands, hundreds, tens, units}.
- `value_valid`, output, 1: one-cycle pulse when `bcd_value` is updated.
- `blank_mask`, output, 4: digits that were blank in the published frame.
- `frame_error`, output, 1: sticky flag; an illegal select or segment pattern was seen in the current frame.

## Operation
- Select classification:
  - Exactly one bit low: legal digit.
  - 4'b1111: inter-digit gap, ignored. The settle counter is held at 0.
  - Anything else: illegal. Sets `frame_error`; the sample is discarded.
- Settle FSM states:
  - `IDLE`: select is a gap.
  - `SETTLING`: counter increments while inputs equal their previous-cycle values. Any change restarts the count at 1 with the new values.
  - `SAMPLED`: count reached `SETTLE_CYCLES`. Exactly one sample is taken for this dwell; the FSM stays here until the inputs change, then goes to `SETTLING` or `IDLE`.
- Sample:
  - Segment pattern decoded to BCD 0–9 using the standard glyphs.
  - Unknown pattern: sets `frame_error`; the digit is not recorded.
- Frame assembly:
  - Each recorded sample writes its digit slot and sets that slot's bit in a 4-bit capture mask. A repeated digit overwrites the slot.
  - When the mask becomes 4'b1111, the frame is complete. The mask clears the same cycle.
- Confirmation:
  - Complete frame (digits plus blank bits) equal to the previous complete frame: the stable counter increments, saturating at `CONFIRM_FRAMES`. Otherwise the counter is set to 1.
  - When the counter reaches `CONFIRM_FRAMES`:
    - Publish `bcd_value` and `blank_mask`.
    - Pulse `value_valid` once per stable run; the value is not re-published while it stays stable.
- `frame_error` clears when a new frame starts, i.e. on the first recorded digit after completion. Its state is unrelated to publishing.
- Reset mid-operation: all state discarded (FSM, mask, slots, previous frame, counters). No output pulse is produced by reset itself.

## Timing
- Reset values:
  - `bcd_value` = 16'h0000, `blank_mask` = 4'b0000.
  - `value_valid` = 0, `frame_error` = 0.
  - FSM `IDLE`, counters 0.
- Sample cycle: the `SETTLE_CYCLES`-th consecutive cycle of stable legal inputs, counting the first cycle of the new value.
- Publish latency: `value_valid` and the new `bcd_value` are registered and appear 1 cycle after the completing sample's clock edge.
- `frame_error` asserts 1 cycle after the offending cycle.
- Completion and the first digit of the next frame never coincide: one sample per dwell, and a dwell lasts ≥`SETTLE_CYCLES`.
- With `CONFIRM_FRAMES`=1, every changed complete frame publishes.

## Configuration
- `DISPLAY_CAPTURE_BLANK_EN`:
  - Defined: all-segments-off (7'b1111111) under a legal select is a valid blank digit. The slot records BCD 0 and its `blank_mask` bit is set, supporting leading-zero blanking.
  - Undefined: the blank pattern is an unknown pattern (sets `frame_error`, digit not recorded). `blank_mask` is tied to 4'b0000.

## Structure
- Shared package `display_pkg`:
  - Segment glyph constants `SEG_0`..`SEG_9` and `SEG_BLANK` (active-low).
  - Digit index constants (`DIG_UNITS`..`DIG_THOUSANDS`).
  - Settle FSM state typedef.
- Sub-module `seg7_to_bcd`: combinational pattern → {bcd[3:0], is_blank, is_valid}, using the package glyphs.
- Top level holds the settle FSM, capture mask, slots, frame comparison and publish logic.

## Test plan
- Drive 1234 as four dwells of 8 cycles each (selects 1110/1101/1011/0111 with glyphs 4/3/2/1), repeated ×2 → one `value_valid` pulse after the second frame, `bcd_value`=16'h1234, `frame_error`=0.
- Change to 0786 with the thousands digit blank (BLANK_EN defined) → `bcd_value`=16'h0786, `blank_mask`=4'b1000. With BLANK_EN undefined → `frame_error`=1 and no publish.
- Glitch dwells of 3 cycles (< `SETTLE_CYCLES`) carrying wrong glyphs, interleaved with valid dwells → glitches ignored, 16'h1234 still published.
- `display_select`=4'b1100 for 6 cycles → `frame_error`=1 on the next cycle; it clears when the next frame's first digit is recorded.
- Stable 1234 for 5 frames → exactly one `value_valid` pulse; then one frame of 1235 followed by 1234 ×2 → one further pulse, value 16'h1234.
- Assert `reset` mid-frame after 2 digits → outputs return to reset values; the next 2 complete frames publish normally.
